// File: rtl/fir.sv
// fir: 4-tap direct-form FIR filter, unsigned arithmetic, registered output.
//   y[n] = c0*x[n] + c1*x[n-1] + c2*x[n-2] + c3*x[n-3]
//
// Optional build macro: FIR_VLD_GATE_EN
//   defined   : the filter advances only on edges where in_data_vld=1
//   undefined : every rising edge out of reset advances; in_data_vld is ignored
//
// Ports
//   clk          in   1       rising-edge clock
//   reset        in   1       asynchronous, active-low reset
//   x_in         in   DATA_W  unsigned input sample
//   in_data_vld  in   1       sample qualifier (used only with FIR_VLD_GATE_EN)
//   c0..c3       in   COEF_W  unsigned tap coefficients, c0 on newest sample
//   y_out        out  OUT_W   registered filter result
module fir #(
    parameter int unsigned DATA_W = 17,
    parameter int unsigned COEF_W = 17,
    parameter int unsigned OUT_W  = DATA_W + COEF_W + 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] x_in,
    input  logic              in_data_vld,
    input  logic [COEF_W-1:0] c0,
    input  logic [COEF_W-1:0] c1,
    input  logic [COEF_W-1:0] c2,
    input  logic [COEF_W-1:0] c3,
    output logic [OUT_W-1:0]  y_out
);

    localparam int unsigned PROD_W = DATA_W + COEF_W;

    logic [DATA_W-1:0] r_d0;
    logic [DATA_W-1:0] r_d1;
    logic [DATA_W-1:0] r_d2;
    logic [OUT_W-1:0]  r_y;

    logic [PROD_W-1:0] w_p0;
    logic [PROD_W-1:0] w_p1;
    logic [PROD_W-1:0] w_p2;
    logic [PROD_W-1:0] w_p3;
    logic [OUT_W-1:0]  w_sum;
    logic              w_adv;

    // Advance qualifier
`ifdef FIR_VLD_GATE_EN
    assign w_adv = in_data_vld;
`else
    logic w_unused_vld;
    assign w_unused_vld = in_data_vld;
    assign w_adv        = 1'b1;
`endif

    // Tap products against the pre-edge delay line; coefficients are not latched
    assign w_p0 = PROD_W'(c0) * PROD_W'(x_in);
    assign w_p1 = PROD_W'(c1) * PROD_W'(r_d0);
    assign w_p2 = PROD_W'(c2) * PROD_W'(r_d1);
    assign w_p3 = PROD_W'(c3) * PROD_W'(r_d2);

    // Two guard bits absorb the carry of the four-way sum
    assign w_sum = OUT_W'(w_p0) + OUT_W'(w_p1) + OUT_W'(w_p2) + OUT_W'(w_p3);

    // Delay line and output register; hold on non-advancing edges
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_d0 <= '0;
            r_d1 <= '0;
            r_d2 <= '0;
            r_y  <= '0;
        end else if (w_adv) begin
            r_d0 <= x_in;
            r_d1 <= r_d0;
            r_d2 <= r_d1;
            r_y  <= w_sum;
        end
    end

    assign y_out = r_y;

endmodule

// File: tb/tb_fir.sv
// tb_fir: self-checking bench for fir (table vectors, corner sequences, random vs model).
module tb_fir;

    localparam int unsigned DATA_W = 17;
    localparam int unsigned COEF_W = 17;
    localparam int unsigned OUT_W  = 36;

`ifdef FIR_VLD_GATE_EN
    localparam logic TBL_VLD = 1'b1;
`else
    localparam logic TBL_VLD = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic [DATA_W-1:0] x_in;
    logic              in_data_vld;
    logic [COEF_W-1:0] c0, c1, c2, c3;
    logic [OUT_W-1:0]  y_out;

    int n_err = 0;
    int n_chk = 0;

    // Reference model: sample history (newest first) and expected output
    longint unsigned m_h [4];
    longint unsigned m_y;

    typedef struct {
        bit                rst_before;
        logic [DATA_W-1:0] x;
        logic [COEF_W-1:0] c0, c1, c2, c3;
        logic [OUT_W-1:0]  y;
    } vec_t;

    vec_t tbl[$];

    fir #(.DATA_W(DATA_W), .COEF_W(COEF_W), .OUT_W(OUT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .x_in       (x_in),
        .in_data_vld(in_data_vld),
        .c0         (c0),
        .c1         (c1),
        .c2         (c2),
        .c3         (c3),
        .y_out      (y_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) m_h[i] = 0;
        m_y = 0;
    endtask

    // Update the model with the values present at the coming edge, then take the edge
    task automatic step();
        bit adv;
        adv = (reset === 1'b1);
`ifdef FIR_VLD_GATE_EN
        adv = adv && (in_data_vld === 1'b1);
`endif
        if (adv) begin
            m_h[3] = m_h[2];
            m_h[2] = m_h[1];
            m_h[1] = m_h[0];
            m_h[0] = 64'(x_in);
            m_y = 64'(c0) * m_h[0] + 64'(c1) * m_h[1] + 64'(c2) * m_h[2] + 64'(c3) * m_h[3];
        end
        @(posedge clk);
        #1;
    endtask

    // Pulse reset between edges and check that the output clears without a clock
    task automatic pulse_reset();
        reset = 1'b0;
        #1;
        model_clear();
        check("reset_async_clear", y_out, '0);
        #1;
        reset = 1'b1;
    endtask

    task automatic set_coefs(input int unsigned a, input int unsigned b, input int unsigned c, input int unsigned d);
        c0 = COEF_W'(a);
        c1 = COEF_W'(b);
        c2 = COEF_W'(c);
        c3 = COEF_W'(d);
    endtask

    initial begin
        int unsigned seq_x [11];
        int unsigned seq_y [11];
        vec_t v;

        seq_x = '{3, 2, 1, 0, 1, 2, 3, 0, 0, 0, 0};
        seq_y = '{0, 3, 8, 14, 8, 4, 4, 10, 12, 9, 0};

        // Impulse response, c = 1,2,3,4
        for (int i = 0; i < 5; i++) begin
            v.rst_before = (i == 0);
            v.x  = (i == 0) ? DATA_W'(1) : '0;
            v.c0 = 1; v.c1 = 2; v.c2 = 3; v.c3 = 4;
            v.y  = (i < 4) ? OUT_W'(i + 1) : '0;
            tbl.push_back(v);
        end
        // Sample sequence, c = 0,1,2,3
        for (int i = 0; i < 11; i++) begin
            v.rst_before = (i == 0);
            v.x  = DATA_W'(seq_x[i]);
            v.c0 = 0; v.c1 = 1; v.c2 = 2; v.c3 = 3;
            v.y  = OUT_W'(seq_y[i]);
            tbl.push_back(v);
        end

        reset = 1'b0;
        x_in = '0;
        in_data_vld = 1'b0;
        set_coefs(7, 7, 7, 7);
        model_clear();

        // Reset state before any clock edge, and while clocks run in reset
        #1;
        check("reset_initial", y_out, '0);
        x_in = 17'd5;
        in_data_vld = 1'b1;
        @(posedge clk); #1;
        check("reset_held_edge1", y_out, '0);
        @(posedge clk); #1;
        check("reset_held_edge2", y_out, '0);
        reset = 1'b1;
        in_data_vld = TBL_VLD;

        // Table-driven vectors
        foreach (tbl[i]) begin
            if (tbl[i].rst_before) pulse_reset();
            x_in = tbl[i].x;
            set_coefs(tbl[i].c0, tbl[i].c1, tbl[i].c2, tbl[i].c3);
            in_data_vld = TBL_VLD;
            step();
            check($sformatf("table[%0d]", i), y_out, tbl[i].y);
        end

        // Maximum values: no wrap
        pulse_reset();
        set_coefs(131071, 131071, 131071, 131071);
        x_in = 17'h1FFFF;
        in_data_vld = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            if (i >= 3) check($sformatf("max_value_edge%0d", i + 1), y_out, 36'd68718428164);
        end

        // Reset mid-stream discards history
        pulse_reset();
        set_coefs(0, 1, 2, 3);
        in_data_vld = TBL_VLD;
        for (int i = 0; i < 4; i++) begin
            x_in = DATA_W'(seq_x[i]);
            step();
        end
        check("midstream_before_reset", y_out, 36'd14);
        reset = 1'b0;
        #1;
        model_clear();
        check("midstream_async_clear", y_out, '0);
        x_in = '0;
        @(posedge clk); #1;
        check("midstream_held", y_out, '0);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("midstream_after_release%0d", i), y_out, '0);
        end

`ifdef FIR_VLD_GATE_EN
        // Gating: valid only on alternate cycles, junk samples in between
        pulse_reset();
        set_coefs(0, 1, 2, 3);
        for (int i = 0; i < 11; i++) begin
            x_in = DATA_W'(seq_x[i]);
            in_data_vld = 1'b1;
            step();
            check($sformatf("gate_valid%0d", i), y_out, OUT_W'(seq_y[i]));
            x_in = DATA_W'($urandom);
            in_data_vld = 1'b0;
            step();
            check($sformatf("gate_hold%0d", i), y_out, OUT_W'(seq_y[i]));
        end
        pulse_reset();
        in_data_vld = 1'b0;
        for (int i = 0; i < 6; i++) begin
            x_in = DATA_W'($urandom);
            step();
            check("gate_never_valid", y_out, '0);
        end
`endif

        // Randomized stimulus against the model, with occasional resets
        pulse_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 49) == 0) pulse_reset();
            x_in = DATA_W'($urandom);
            in_data_vld = 1'($urandom);
            if ($urandom_range(0, 3) == 0)
                set_coefs($urandom, $urandom, $urandom, $urandom);
            step();
            check($sformatf("random[%0d]", i), y_out, OUT_W'(m_y));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
